// File: rtl/comb_sequencer.sv
// comb_sequencer: walks every (i,j) pair in 1..MAX_INDEX, derives
// k = sum - i - j and hands out each triple (i,j,k) whose k also lies in
// 1..MAX_INDEX over a valid/ready handshake, counting hand-offs and
// flagging runs that find more triples than MAX_COMBS.
// Optional feature: define COMB_SEQ_ABORT_EN to add an 'abort' input that
// cuts a run short (straight to FIN with a done pulse).
module comb_sequencer #(
    parameter int MAX_INDEX = 7,
    parameter int MAX_COMBS = 39
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] sum,
`ifdef COMB_SEQ_ABORT_EN
    input  logic       abort,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_a,
    output logic [2:0] out_b,
    output logic [2:0] out_c,
    output logic [5:0] count,
    output logic       busy,
    output logic       done,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [2:0] LAST_IDX  = 3'(MAX_INDEX);
    localparam logic [5:0] COUNT_CAP = 6'(MAX_COMBS);

    state_t state;
    state_t state_next;

    logic [7:0]        sum_q;
    logic [2:0]        i;
    logic [2:0]        j;
    logic signed [9:0] k;
    logic              pair_valid;
    logic              last_pair;
    logic              can_emit;
    logic              abort_req;

`ifdef COMB_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Pair evaluation: third element and whether this pair yields a usable triple
    always_comb begin
        k          = $signed({2'b00, sum_q}) - $signed({7'b0, i}) - $signed({7'b0, j});
        pair_valid = (k >= 10'sd1) && (k <= $signed(10'(MAX_INDEX)));
        last_pair  = (i == LAST_IDX) && (j == LAST_IDX);
        can_emit   = pair_valid && (count != COUNT_CAP);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort wins over a same-cycle handshake
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (abort_req) begin
                    state_next = FIN;
                end else if (can_emit) begin
                    state_next = EMIT;
                end else if (last_pair) begin
                    state_next = FIN;
                end
            end
            EMIT: begin
                if (abort_req) begin
                    state_next = FIN;
                end else if (out_ready) begin
                    state_next = last_pair ? FIN : SCAN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs decoded straight from the state
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == FIN);
        out_valid = (state == EMIT);
    end

    // Datapath: captured sum, pair counters, presented triple, count and overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q    <= 8'd0;
            i        <= 3'd1;
            j        <= 3'd1;
            out_a    <= 3'd0;
            out_b    <= 3'd0;
            out_c    <= 3'd0;
            count    <= 6'd0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sum_q    <= sum;
                        i        <= 3'd1;
                        j        <= 3'd1;
                        count    <= 6'd0;
                        overflow <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!abort_req) begin
                        if (can_emit) begin
                            out_a <= i;
                            out_b <= j;
                            out_c <= k[2:0];
                        end else begin
                            if (pair_valid) begin
                                overflow <= 1'b1;
                            end
                            if (!last_pair) begin
                                if (j == LAST_IDX) begin
                                    j <= 3'd1;
                                    i <= i + 3'd1;
                                end else begin
                                    j <= j + 3'd1;
                                end
                            end
                        end
                    end
                end
                EMIT: begin
                    if (!abort_req && out_ready) begin
                        count <= count + 6'd1;
                        if (!last_pair) begin
                            if (j == LAST_IDX) begin
                                j <= 3'd1;
                                i <= i + 3'd1;
                            end else begin
                                j <= j + 3'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comb_sequencer.sv
// tb_comb_sequencer: drives comb_sequencer with directed and randomized runs
// and compares every handed-off triple, the final count/overflow and the
// done timing against a list of triples enumerated directly from sum.
module tb_comb_sequencer;

    localparam int MAX_INDEX = 7;
    localparam int MAX_COMBS = 39;

    typedef struct {
        int a;
        int b;
        int c;
    } triple_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] sum;
    logic       outReady;
    logic       outValid;
    logic [2:0] outA;
    logic [2:0] outB;
    logic [2:0] outC;
    logic [5:0] count;
    logic       busy;
    logic       done;
    logic       overflow;
`ifdef COMB_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif

    int      totalChecks = 0;
    int      badChecks   = 0;
    triple_t expQ[$];
    int      expOverflow;

    comb_sequencer #(
        .MAX_INDEX(MAX_INDEX),
        .MAX_COMBS(MAX_COMBS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sum      (sum),
`ifdef COMB_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .out_valid(outValid),
        .out_ready(outReady),
        .out_a    (outA),
        .out_b    (outB),
        .out_c    (outC),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        totalChecks++;
        if (observed != expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: enumerate (a,b) lexicographically, keep those whose c fits
    function automatic void buildModel(input int s);
        triple_t t;
        expQ.delete();
        expOverflow = 0;
        for (int a = 1; a <= MAX_INDEX; a++) begin
            for (int b = 1; b <= MAX_INDEX; b++) begin
                int c;
                c = s - a - b;
                if (c >= 1 && c <= MAX_INDEX) begin
                    if (expQ.size() < MAX_COMBS) begin
                        t.a = a;
                        t.b = b;
                        t.c = c;
                        expQ.push_back(t);
                    end else begin
                        expOverflow = 1;
                    end
                end
            end
        end
    endfunction

    // readyMode: 0 = always ready, 1 = random ready plus noise on start/sum,
    // 2 = first presented triple stalled 5 cycles then always ready
    task automatic applyStimulus(input int s, input int readyMode, input int expDoneCycle);
        int  expCount;
        int  seen     = 0;
        int  cyc      = 0;
        int  holdCnt  = 0;
        bit  prevStall = 0;
        bit  gotDone  = 0;
        int  pa = 0, pb = 0, pc = 0;
        buildModel(s);
        expCount = expQ.size();
        @(negedge clk);
        start    = 1'b1;
        sum      = s[7:0];
        outReady = 1'b1;
        for (cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            #1;
            if (readyMode == 1) begin
                start    = 1'($urandom_range(0, 1));
                sum      = 8'($urandom);
                outReady = ($urandom_range(0, 3) != 0);
            end else if (readyMode == 2) begin
                start = 1'b0;
                if (outValid && holdCnt < 5) begin
                    outReady = 1'b0;
                    holdCnt++;
                end else begin
                    outReady = 1'b1;
                end
            end else begin
                start    = 1'b0;
                outReady = 1'b1;
            end
            if (cyc == 1) begin
                checkOutput("busy_after_start", int'(busy), 1);
            end
            if (prevStall) begin
                checkOutput("hold_valid", int'(outValid), 1);
                checkOutput("hold_a", int'(outA), pa);
                checkOutput("hold_b", int'(outB), pb);
                checkOutput("hold_c", int'(outC), pc);
            end
            prevStall = outValid && !outReady;
            pa = int'(outA);
            pb = int'(outB);
            pc = int'(outC);
            if (outValid && outReady) begin
                if (seen < expCount) begin
                    checkOutput($sformatf("triple%0d_a", seen), int'(outA), expQ[seen].a);
                    checkOutput($sformatf("triple%0d_b", seen), int'(outB), expQ[seen].b);
                    checkOutput($sformatf("triple%0d_c", seen), int'(outC), expQ[seen].c);
                end else begin
                    checkOutput("too_many_triples", seen + 1, expCount);
                end
                seen++;
            end
            if (done) begin
                gotDone = 1'b1;
                break;
            end
        end
        checkOutput($sformatf("done_seen_sum%0d", s), int'(gotDone), 1);
        if (expDoneCycle >= 0) begin
            checkOutput($sformatf("done_latency_sum%0d", s), cyc, expDoneCycle);
        end
        if (readyMode == 2 && expCount > 0) begin
            checkOutput("stall_cycles", holdCnt, 5);
        end
        checkOutput($sformatf("triples_seen_sum%0d", s), seen, expCount);
        checkOutput($sformatf("count_sum%0d", s), int'(count), expCount);
        checkOutput($sformatf("overflow_sum%0d", s), int'(overflow), expOverflow);
        @(negedge clk);
        start    = 1'b0;
        outReady = 1'b1;
        #1;
        checkOutput("done_one_cycle", int'(done), 0);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("count_held", int'(count), expCount);
    endtask

    // Reset mid-run: drop rst while the third triple is presented
    task automatic resetDuringEmit();
        int seen = 0;
        bit found = 0;
        int doneSeen = 0;
        @(negedge clk);
        start    = 1'b1;
        sum      = 8'd12;
        outReady = 1'b1;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            #1;
            start = 1'b0;
            if (outValid) begin
                if (seen == 2) begin
                    found = 1'b1;
                    break;
                end
                seen++;
            end
        end
        checkOutput("third_triple_reached", int'(found), 1);
        outReady = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_valid", int'(outValid), 0);
        checkOutput("rst_abc", int'({outA, outB, outC}), 0);
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        @(negedge clk);
        rst      = 1'b0;
        outReady = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            #1;
            if (done) begin
                doneSeen++;
            end
        end
        checkOutput("no_done_after_reset", doneSeen, 0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        sum      = 8'd0;
        outReady = 1'b0;
        #12;
        checkOutput("reset_valid", int'(outValid), 0);
        checkOutput("reset_abc", int'({outA, outB, outC}), 0);
        checkOutput("reset_count", int'(count), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_overflow", int'(overflow), 0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(3, 0, 51);
        applyStimulus(21, 0, 51);
        applyStimulus(2, 0, 50);
        applyStimulus(12, 0, 87);
        applyStimulus(12, 2, 92);
        applyStimulus(25, 0, 50);
        repeat (6) begin
            applyStimulus(int'($urandom_range(0, 30)), 1, -1);
        end
        resetDuringEmit();
        applyStimulus(3, 0, 51);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/comb_sequencer.md
COMB_SEQUENCER -- requirements
Module: comb_sequencer

Interface
REQ-001 SHALL have parameter MAX_INDEX, default 7: the largest value any triple element may take.
REQ-002 SHALL have parameter MAX_COMBS, default 39: the capacity of the emitted-triple counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: requests an enumeration; sampled only in IDLE.
REQ-006 SHALL have port sum, input, 8 bits unsigned: the target total, captured when start is accepted.
REQ-007 SHALL have port out_valid, output, 1 bit: a triple is presented on out_a/out_b/out_c.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts the presented triple.
REQ-009 SHALL have ports out_a, out_b, out_c, output, 3 bits each: the triple elements, each in 1..MAX_INDEX.
REQ-010 SHALL have port count, output, 6 bits: the number of triples handed off in the current or last run.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: a one-cycle pulse at the end of a run.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, set when a run produces more valid triples than MAX_COMBS.

Function
REQ-014 SHALL implement four states: IDLE, SCAN, EMIT, FIN.
REQ-015 IDLE, when start=1: SHALL capture sum, set i=1 and j=1, clear count and overflow, and enter SCAN on the next edge.
REQ-016 SCAN: SHALL evaluate one (i,j) pair per cycle, with k = sum - i - j computed in 10-bit signed arithmetic.
REQ-017 A pair SHALL be valid iff 1 <= k <= MAX_INDEX.
REQ-018 SCAN, valid pair: SHALL register out_a=i, out_b=j, out_c=k[2:0], assert out_valid, and enter EMIT.
REQ-019 SCAN, invalid pair: SHALL advance the pair and remain in SCAN.
REQ-020 Pair advance order SHALL be j++; when j=MAX_INDEX, set j=1 and increment i.
REQ-021 When the pair (MAX_INDEX, MAX_INDEX) completes, the FSM SHALL enter FIN instead of advancing.
REQ-022 EMIT: out_valid and out_a/out_b/out_c SHALL hold stable until out_ready=1.
REQ-023 EMIT handshake (out_valid & out_ready): SHALL deassert out_valid, increment count, and then advance the pair, or enter FIN if the pair is the last one.
REQ-024 When a valid triple is found while count=MAX_COMBS: SHALL not emit it, SHALL set overflow, and scanning SHALL continue.
REQ-025 FIN: SHALL pulse done for exactly one cycle and return to IDLE.
REQ-026 count and overflow SHALL hold their values in IDLE until the next accepted start.
REQ-027 start outside IDLE SHALL be ignored, and sum changes outside IDLE SHALL have no effect.
REQ-028 When sum < 3 or sum > 3*MAX_INDEX: all pairs are scanned, no triple is emitted, and done is asserted with count=0 after MAX_INDEX^2 SCAN cycles.
REQ-029 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-030 While rst=1, regardless of clk: state=IDLE, out_valid=0, out_a/out_b/out_c=0, count=0, busy=0, done=0, overflow=0, i=j=1.
REQ-031 Reset asserted mid-run SHALL abandon the run with no done pulse; start SHALL be honoured on the first edge after rst deasserts.

Configuration
REQ-032 With macro COMB_SEQ_ABORT_EN defined: SHALL add port abort, input, 1 bit; abort=1 in SCAN or EMIT SHALL drop out_valid and enter FIN (done pulses, count holds the handshakes already completed).
REQ-033 Without COMB_SEQ_ABORT_EN: the abort port SHALL not exist, and every run SHALL complete all MAX_INDEX^2 pairs.

Verification
REQ-034 sum=3, out_ready=1 -> exactly one triple (1,1,1); done pulses with count=1, overflow=0.
REQ-035 sum=21 -> single triple (7,7,7) emitted on the last pair; count=1.
REQ-036 sum=2 -> no out_valid; done 50 cycles after start (1 IDLE + 49 SCAN); count=0.
REQ-037 sum=12, out_ready=1 -> 37 triples in lexicographic (a,b) order, first (1,4,7), last (7,4,1); count=37, overflow=0.
REQ-038 sum=12 with out_ready held low for 5 cycles on the first triple -> out_valid and (1,4,7) stable for all 5 cycles, and the sequence is otherwise unchanged.
REQ-039 rst pulse during EMIT of the 3rd triple -> outputs immediately at reset values and no done; a new start with sum=3 completes normally.
